pc_fetch_seq: RTL
=================

Name: pc_fetch_seq

Overview:
Program-counter and instruction-fetch sequencer for the RV523 core. It drives the fetch address and the handshake to instruction memory, and hands each fetched word to decode. It is synthesised onto the RV523 standard-cell set: NOR2 and the other NMOS/PMOS cells supply the gate logic, and this block supplies the state. It sits directly upstream of the decode logic those cells implement.

Parameters:
XLEN, 32, PC and instruction width in bits.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
INC, 4, PC increment per sequential fetch; must be a power of two and less than 2^XLEN.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
MEM_ADDR  output  XLEN  fetch address presented to instruction memory.
MEM_REQ  output  1  fetch request to memory.
MEM_ACK  input  1  memory accepted the request; MEM_RDATA is valid in the same cycle.
MEM_RDATA  input  XLEN  instruction word from memory.
REDIR  input  1  branch/jump redirect request from execute.
REDIR_PC  input  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
STALL  input  1  decode cannot accept a new instruction.
INSN  output  XLEN  instruction delivered to decode.
INSN_PC  output  XLEN  PC of INSN.
INSN_VALID  output  1  INSN/INSN_PC hold a valid instruction.

Behaviour:
- Reset: RST is sampled on a rising CLK edge. It overrides all other inputs. After reset:
  - PC = RESET_VEC, state = IDLE
  - MEM_REQ = 0, INSN_VALID = 0, INSN = 0, INSN_PC = 0
  - pending_redir = 0
  Reset asserted mid-fetch abandons the fetch; a MEM_ACK in the reset cycle is ignored.
- State machine: IDLE, REQ, HOLD.
  - IDLE -> REQ on the cycle after reset deasserts.
  - REQ:
    - MEM_REQ = 1 and MEM_ADDR = PC, held stable until MEM_ACK.
    - On MEM_ACK with no redirect pending: capture INSN = MEM_RDATA, INSN_PC = PC, set INSN_VALID = 1, set PC = PC + INC (wrap modulo 2^XLEN).
    - Next state is REQ if STALL = 0, else HOLD.
  - HOLD:
    - MEM_REQ = 0; INSN, INSN_PC and INSN_VALID are held.
    - When STALL = 0 at the sampling edge, decode consumes the instruction and the block returns to REQ.
    - If no new instruction is captured in that cycle, INSN_VALID is cleared.
- Decode handshake: decode consumes an instruction on each edge where INSN_VALID = 1 and STALL = 0. When a new MEM_ACK arrives in the same cycle as a consume, the new word replaces the old one back-to-back and INSN_VALID stays 1. Throughput is one instruction per cycle when MEM_ACK is held high.
- Redirect:
  - On REDIR = 1 in any non-reset state: PC = {REDIR_PC[XLEN-1:2], 2'b00}, INSN_VALID = 0 on the next edge, and the state goes to REQ.
  - REDIR and MEM_ACK in the same cycle: the acked word is discarded and the redirect target is fetched next.
  - REDIR with STALL = 1: the redirect still wins and the held instruction is flushed.
  - REDIR while in REQ without ACK: the request continues, but MEM_ADDR changes to the new PC on the next cycle. Memory must tolerate an address change while no ACK is given.
  - pending_redir covers a REDIR raised in a cycle where the state is leaving HOLD. It is applied on the next edge and cleared there.
- Latency:
  - First MEM_REQ: 1 cycle after reset deasserts.
  - INSN_VALID: 1 cycle after MEM_ACK.
  - Redirect to MEM_ADDR update: 1 cycle.
- MEM_ADDR equals PC in every state and changes only on a clock edge.
- Unknown or unused state encodings go to IDLE.

Test Plan:
- Reset then free run: RST high for 2 cycles, MEM_ACK tied to 1, RDATA = address. Required: MEM_ADDR = 0, 4, 8, 12 on consecutive cycles; INSN_VALID goes high 1 cycle after the first ACK; INSN_PC = 0, 4, 8.
- Stall hold: assert STALL for 3 cycles after INSN = 0x00000013 is delivered. Required: INSN, INSN_PC and INSN_VALID are held; MEM_REQ = 0 during the stall; fetch resumes at the next PC when STALL drops.
- Redirect colliding with ACK: REDIR = 1, REDIR_PC = 0x0000_0103, MEM_ACK = 1 in the same cycle. Required: the acked word is dropped, INSN_VALID = 0 on the next cycle, the next MEM_ADDR = 0x0000_0100.
- Wraparound: reset with RESET_VEC = 32'hFFFF_FFFC and ACK always high. Required: MEM_ADDR goes 0xFFFF_FFFC then 0x0000_0000.
- Slow memory: MEM_ACK is delayed 3 cycles. Required: MEM_REQ = 1 and MEM_ADDR stay stable for all 4 cycles; exactly one INSN is delivered.
- Reset mid-fetch: assert RST while in REQ with MEM_ACK = 1. Required: no INSN_VALID pulse; PC = RESET_VEC; MEM_REQ = 0 on the next cycle.

Source files
------------

// File: rtl/pc_fetch_seq.sv
// Program counter and instruction-fetch sequencer: drives the instruction-memory
// request/address and hands each fetched word to decode with a valid/stall handshake.
module pc_fetch_seq #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned     INC       = 4
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic            MEM_REQ,
  input  logic            MEM_ACK,
  input  logic [XLEN-1:0] MEM_RDATA,
  input  logic            REDIR,
  input  logic [XLEN-1:0] REDIR_PC,
  input  logic            STALL,
  output logic [XLEN-1:0] INSN,
  output logic [XLEN-1:0] INSN_PC,
  output logic            INSN_VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] insn_q, insn_d;
  logic [XLEN-1:0] insn_pc_q, insn_pc_d;
  logic            valid_q, valid_d;
  logic            pending_q, pending_d;
  logic            fetch_req;
  logic [XLEN-1:0] redir_target;
  logic            unused_redir_lsbs;

  assign redir_target      = {REDIR_PC[XLEN-1:2], 2'b00};
  assign unused_redir_lsbs = ^REDIR_PC[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VEC;
      insn_q    <= '0;
      insn_pc_q <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      insn_pc_q <= insn_pc_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    insn_pc_d = insn_pc_q;
    valid_d   = valid_q;
    pending_d = 1'b0;
    fetch_req = 1'b0;

    case (state_q)
      IDLE: begin
        if (REDIR) begin
          pc_d = redir_target;
        end
        valid_d = 1'b0;
        state_d = REQ;
      end

      REQ: begin
        // An unconsumed word under stall blocks the request so it cannot be overwritten.
        fetch_req = !(valid_q && STALL);
        if (REDIR) begin
          pc_d    = redir_target;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (fetch_req && MEM_ACK && !pending_q) begin
          insn_d    = MEM_RDATA;
          insn_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + XLEN'(INC);
          state_d   = STALL ? HOLD : REQ;
        end else if (valid_q) begin
          if (STALL) begin
            state_d = HOLD;
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (REDIR) begin
          pc_d      = redir_target;
          valid_d   = 1'b0;
          pending_d = 1'b1;
          state_d   = REQ;
        end else if (!STALL) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MEM_REQ    = fetch_req;
  assign MEM_ADDR   = pc_q;
  assign INSN       = insn_q;
  assign INSN_PC    = insn_pc_q;
  assign INSN_VALID = valid_q;

endmodule
